// File: rtl/dmem_arb_pkg.sv
// Shared types and RISC-V load/store width codes for the data-memory arbiter.
// DMEM_ARB_ROUND_ROBIN_EN (optional) selects round-robin tie-breaking in dmem_arb_pick.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between CPU and DMA; one-hot grant (bit0 = CPU, bit1 = DMA).
// With DMEM_ARB_ROUND_ROBIN_EN defined, ties go to the requester not granted last.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic       cpu_valid,
    input  logic       dma_valid,
    input  req_id_t    last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (cpu_valid && dma_valid) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            grant = (last_grant == REQ_CPU) ? 2'b10 : 2'b01;
`else
            grant = 2'b01;
`endif
        end else if (cpu_valid) begin
            grant = 2'b01;
        end else if (dma_valid) begin
            grant = 2'b10;
        end
    end

`ifndef DMEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; the port stays for a uniform interface.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU/DMA) arbiter for a single-ported data memory: accept, access, respond.
// DMEM_ARB_ROUND_ROBIN_EN enables round-robin ties; otherwise the CPU always wins ties.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [2:0]            cpu_funct3,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req_valid,
    output logic                  dma_req_ready,
    input  logic                  dma_we,
    input  logic [DATA_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic [2:0]            dma_funct3,
    output logic                  dma_rsp_valid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    arb_state_t            state, state_nxt;
    logic [1:0]            grant;
    logic                  accept;
    req_id_t               last_grant;

    logic                  we_p1;
    logic [DATA_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic [2:0]            funct3_p1;
    req_id_t               winner_p1;
    logic [DATA_WIDTH-1:0] rdata_p2;

    dmem_arb_pick u_pick (
        .cpu_valid  (cpu_req_valid),
        .dma_valid  (dma_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_DMA;
        end else if (accept) begin
            last_grant <= grant[1] ? REQ_DMA : REQ_CPU;
        end
    end
`else
    assign last_grant = REQ_DMA;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        cpu_req_ready = 1'b0;
        dma_req_ready = 1'b0;
        cpu_rsp_valid = 1'b0;
        dma_rsp_valid = 1'b0;
        cpu_rdata     = '0;
        dma_rdata     = '0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wd        = '0;
        mem_funct3    = 3'b000;
        case (state)
            ST_IDLE: begin
                // rst_n gates ready so nothing is handshaken while reset is held.
                accept        = rst_n && (cpu_req_valid || dma_req_valid);
                cpu_req_ready = accept && grant[0];
                dma_req_ready = accept && grant[1];
                if (accept) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we     = we_p1;
                mem_addr   = addr_p1;
                mem_wd     = wdata_p1;
                mem_funct3 = funct3_p1;
                state_nxt  = ST_RESP;
            end
            ST_RESP: begin
                if (winner_p1 == REQ_CPU) begin
                    cpu_rsp_valid = 1'b1;
                    cpu_rdata     = rdata_p2;
                end else begin
                    dma_rsp_valid = 1'b1;
                    dma_rdata     = rdata_p2;
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // p1: accepted request; p2: memory read data captured during ACCESS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1     <= 1'b0;
            addr_p1   <= '0;
            wdata_p1  <= '0;
            funct3_p1 <= 3'b000;
            winner_p1 <= REQ_CPU;
            rdata_p2  <= '0;
        end else begin
            if (accept) begin
                we_p1     <= grant[1] ? dma_we     : cpu_we;
                addr_p1   <= grant[1] ? dma_addr   : cpu_addr;
                wdata_p1  <= grant[1] ? dma_wdata  : cpu_wdata;
                funct3_p1 <= grant[1] ? dma_funct3 : cpu_funct3;
                winner_p1 <= grant[1] ? REQ_DMA    : REQ_CPU;
            end
            if (state == ST_ACCESS) begin
                rdata_p2 <= we_p1 ? '0 : mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner sequence, randomized model check.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        cv, cwe;
        logic [31:0] ca, cw;
        logic [2:0]  cf;
        logic        dv, dwe;
        logic [31:0] da, dw;
        logic [2:0]  df;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        crdy, drdy, crv, drv, mwe;
        logic [2:0]  mf;
        logic [31:0] ma, mw, crd, drd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid, cpu_req_ready, cpu_we, cpu_rsp_valid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [2:0]  cpu_funct3;
    logic        dma_req_valid, dma_req_ready, dma_we, dma_rsp_valid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [2:0]  dma_funct3;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic [2:0]  mem_funct3;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_funct3(dma_funct3),
        .dma_rsp_valid(dma_rsp_valid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
        .mem_rd(mem_rd)
    );

    task automatic drive(input in_t v);
        cpu_req_valid = v.cv; cpu_we = v.cwe; cpu_addr = v.ca; cpu_wdata = v.cw; cpu_funct3 = v.cf;
        dma_req_valid = v.dv; dma_we = v.dwe; dma_addr = v.da; dma_wdata = v.dw; dma_funct3 = v.df;
        mem_rd = v.mrd;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = '{crdy: cpu_req_ready, drdy: dma_req_ready, crv: cpu_rsp_valid, drv: dma_rsp_valid,
                mwe: mem_we, mf: mem_funct3, ma: mem_addr, mw: mem_wd, crd: cpu_rdata, drd: dma_rdata};
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (rdy c/d rsp c/d we | f3 | addr | wd | crd | drd)",
                     name, act, exp);
        end
    endtask

    function automatic in_t in_idle(input logic [31:0] mrd);
        in_t v = '0;
        v.mrd = mrd;
        return v;
    endfunction

    function automatic in_t in_one(input bit dma, input logic we, input logic [31:0] a, input logic [31:0] w,
                                   input logic [2:0] f, input logic [31:0] mrd);
        in_t v = '0;
        if (dma) begin
            v.dv = 1'b1; v.dwe = we; v.da = a; v.dw = w; v.df = f;
        end else begin
            v.cv = 1'b1; v.cwe = we; v.ca = a; v.cw = w; v.cf = f;
        end
        v.mrd = mrd;
        return v;
    endfunction

    function automatic in_t in_tie(input logic [31:0] mrd);
        in_t v = '0;
        v.cv = 1'b1; v.cwe = 1'b0; v.ca = 32'h100; v.cw = 32'hC0; v.cf = LW;
        v.dv = 1'b1; v.dwe = 1'b0; v.da = 32'hFC;  v.dw = 32'hD0; v.df = LH;
        v.mrd = mrd;
        return v;
    endfunction

    function automatic out_t o_ready(input bit dma);
        out_t o = '0;
        if (dma) o.drdy = 1'b1;
        else     o.crdy = 1'b1;
        return o;
    endfunction

    function automatic out_t o_mem(input logic we, input logic [31:0] a, input logic [31:0] w, input logic [2:0] f);
        out_t o = '0;
        o.mwe = we; o.ma = a; o.mw = w; o.mf = f;
        return o;
    endfunction

    function automatic out_t o_rsp(input bit dma, input logic [31:0] d);
        out_t o = '0;
        if (dma) begin o.drv = 1'b1; o.drd = d; end
        else     begin o.crv = 1'b1; o.crd = d; end
        return o;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        drive(in_tie(32'hFFFF_FFFF));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", '0);
        drive(in_idle(32'h0));
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model state: transaction timing is derived from the cycle of the last accept.
    vec_t        tbl[$];
    int          cyc, t_acc, d;
    bit          win, m_win, m_we, m_last;
    logic [31:0] m_addr, m_wd, m_cap;
    logic [2:0]  m_f3;
    bit          cp, dp;
    in_t         pend, v;
    out_t        e;

    initial begin
        drive(in_idle(32'h0));
        do_reset();

        // Directed table: CPU lw, DMA sw, then four back-to-back ties.
        tbl.push_back('{in_one(0, 1'b0, 32'h10000, 32'h0, LW, 32'h0), o_ready(0)});
        tbl.push_back('{in_idle(32'hDEADBEEF), o_mem(1'b0, 32'h10000, 32'h0, LW)});
        tbl.push_back('{in_idle(32'h11111111), o_rsp(0, 32'hDEADBEEF)});
        tbl.push_back('{in_one(1, 1'b1, 32'h10004, 32'h12345678, SW, 32'h0), o_ready(1)});
        tbl.push_back('{in_idle(32'hAAAA5555), o_mem(1'b1, 32'h10004, 32'h12345678, SW)});
        tbl.push_back('{in_idle(32'h0), o_rsp(1, 32'h0)});
        tbl.push_back('{in_idle(32'h0), '0});
        for (int k = 0; k < 4; k++) begin
            win = RR ? bit'(k % 2) : 1'b0;
            tbl.push_back('{in_tie(32'h0BADF00D), o_ready(win)});
            tbl.push_back('{in_tie(32'h0BADF00D), o_mem(1'b0, win ? 32'hFC : 32'h100,
                                                       win ? 32'hD0 : 32'hC0, win ? LH : LW)});
            tbl.push_back('{in_tie(32'h0BADF00D), o_rsp(win, 32'h0BADF00D)});
        end
        tbl.push_back('{in_idle(32'h0), '0});

        foreach (tbl[i]) begin
            drive(tbl[i].i);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].o);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a CPU store's memory cycle.
        do_reset();
        drive(in_one(0, 1'b1, 32'h200, 32'h55, SW, 32'h0));
        @(negedge clk);
        check("rst_accept", o_ready(0));
        @(posedge clk);
        #1 drive(in_idle(32'h0));
        @(negedge clk);
        check("rst_access", o_mem(1'b1, 32'h200, 32'h55, SW));
        #1 rst_n = 1'b0;
        #1 check("rst_async_drop", '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_no_rsp%0d", k), '0);
            @(posedge clk);
            #1;
        end
        drive(in_tie(32'h0));
        @(negedge clk);
        check("rst_tie_cpu", o_ready(0));
        @(posedge clk);
        #1 drive(in_idle(32'h13572468));
        @(negedge clk);
        check("rst_tie_mem", o_mem(1'b0, 32'h100, 32'hC0, LW));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_tie_rsp", o_rsp(0, 32'h13572468));
        @(posedge clk);
        #1;

        // Randomized traffic against the timing/priority model.
        do_reset();
        cyc = 0; t_acc = -100; m_last = 1'b1; m_cap = '0;
        m_win = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_f3 = '0;
        cp = 1'b0; dp = 1'b0; pend = '0;
        for (int n = 0; n < 600; n++) begin
            v = '0;
            v.cw = $urandom; v.dw = $urandom; v.ca = $urandom; v.da = $urandom;
            if (!cp && $urandom_range(0, 2) == 0) begin
                cp = 1'b1; pend.cwe = 1'($urandom); pend.cw = $urandom; pend.cf = 3'($urandom);
                pend.ca = ($urandom_range(0, 7) == 0) ? 32'hFC : $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; pend.dwe = 1'($urandom); pend.dw = $urandom; pend.df = 3'($urandom);
                pend.da = ($urandom_range(0, 7) == 0) ? 32'hFC : $urandom;
            end
            if (cp) begin v.cv = 1'b1; v.cwe = pend.cwe; v.ca = pend.ca; v.cw = pend.cw; v.cf = pend.cf; end
            if (dp) begin v.dv = 1'b1; v.dwe = pend.dwe; v.da = pend.da; v.dw = pend.dw; v.df = pend.df; end
            v.mrd = $urandom;
            drive(v);
            @(negedge clk);
            e = '0;
            d = cyc - t_acc;
            win = 1'b0;
            if (d == 1) begin
                e = o_mem(m_we, m_addr, m_wd, m_f3);
            end else if (d == 2) begin
                e = o_rsp(m_win, m_cap);
            end else if (cp || dp) begin
                win = (cp && dp) ? (RR ? ~m_last : 1'b0) : dp;
                e = o_ready(win);
            end
            check($sformatf("rand%0d", n), e);
            @(posedge clk);
            if (d == 1) m_cap = m_we ? 32'h0 : v.mrd;
            if (d >= 3 && (cp || dp)) begin
                t_acc  = cyc;
                m_win  = win;
                m_we   = win ? v.dwe : v.cwe;
                m_addr = win ? v.da  : v.ca;
                m_wd   = win ? v.dw  : v.cw;
                m_f3   = win ? v.df  : v.cf;
                m_last = win;
                if (win) dp = 1'b0;
                else     cp = 1'b0;
            end
            cyc++;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
